// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch + load/store) in front
// of a single shared memory port with in-order responses.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties.
// Without it, the LSU always wins a tie (fixed priority).
//
// Parameters:
//   MAX_OUTST    - granted transactions that may await rvalid (1..4)
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   if_*                    - read-only instruction-fetch requester
//   lsu_*                   - load/store requester (we, be, wdata)
//   mem_*                   - shared memory port (req/gnt + in-order rvalid)
//   err_o                   - sticky flag: rvalid seen with nothing outstanding
module mem_arbiter #(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam logic       ID_IF    = 1'b0;
  localparam logic       ID_LSU   = 1'b1;
  localparam logic [2:0] DEPTH    = 3'(MAX_OUTST);
  localparam logic [1:0] PTR_LAST = 2'(MAX_OUTST - 1);

  // Storage is sized for the largest legal depth; pointers wrap at MAX_OUTST.
  logic       id_fifo [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       lock_valid;
  logic       lock_id;
  logic       err_q;
`ifdef MEM_ARB_RR_EN
  logic       last_grant;
`endif

  logic sel_id;
  logic sel_req;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic req_ok;
  logic grant;
  logic head_id;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Winner selection: a held lock overrides arbitration so that a stalled
  // request keeps its payload stable until the memory accepts it.
  always_comb begin
    sel_id = ID_IF;
    if (lock_valid) begin
      sel_id = lock_id;
    end else if (if_req_i && lsu_req_i) begin
`ifdef MEM_ARB_RR_EN
      sel_id = (last_grant == ID_LSU) ? ID_IF : ID_LSU;
`else
      sel_id = ID_LSU;
`endif
    end else if (lsu_req_i) begin
      sel_id = ID_LSU;
    end
  end

  // A pop in this cycle frees a slot, so a full FIFO only blocks new
  // requests when no response is arriving.
  assign sel_req    = (sel_id == ID_LSU) ? lsu_req_i : if_req_i;
  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == DEPTH);
  assign pop        = rst_ni && mem_rvalid_i && !fifo_empty;
  assign req_ok     = rst_ni && sel_req && !(fifo_full && !pop);
  assign grant      = req_ok && mem_gnt_i;
  assign head_id    = id_fifo[rd_ptr];
  assign err_o      = err_q;

  // Request/response routing; everything not owned by the winner or the
  // FIFO head is held at zero.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'h0;
    mem_addr_o   = 32'h0;
    mem_wdata_o  = 32'h0;
    if_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    lsu_rvalid_o = 1'b0;
    if_rdata_o   = 32'h0;
    lsu_rdata_o  = 32'h0;
    if (req_ok) begin
      mem_req_o = 1'b1;
      if (sel_id == ID_LSU) begin
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_be_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
        lsu_gnt_o   = mem_gnt_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = if_addr_i;
        if_gnt_o    = mem_gnt_i;
      end
    end
    if (pop) begin
      if (head_id == ID_LSU) begin
        lsu_rvalid_o = 1'b1;
        lsu_rdata_o  = mem_rdata_i;
      end else begin
        if_rvalid_o  = 1'b1;
        if_rdata_o   = mem_rdata_i;
      end
    end
  end

  // ID storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      id_fifo[wr_ptr] <= sel_id;
    end
  end

  // FIFO pointers, occupancy, lock and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      lock_valid <= 1'b0;
      lock_id    <= ID_IF;
      err_q      <= 1'b0;
    end else begin
      if (grant) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({grant, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // A lock is taken when a request is presented but not accepted, and
      // survives a FIFO-full stall because req_ok drops while sel_req holds.
      if (grant) begin
        lock_valid <= 1'b0;
      end else if (req_ok && !mem_gnt_i) begin
        lock_valid <= 1'b1;
        lock_id    <= sel_id;
      end else if (lock_valid && !sel_req) begin
        lock_valid <= 1'b0;
      end
      if (mem_rvalid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Resets to IF so the LSU wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= ID_IF;
    end else if (grant) begin
      last_grant <= sel_id;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_OUTST, default 2, meaning the maximum number of granted transactions awaiting rvalid; legal values are 1 to 4.
REQ-002 Port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst_ni, input, 1 bit, reset, asynchronous and active-low.
REQ-004 Ports if_req_i (in, 1), if_addr_i (in, 32), if_gnt_o (out, 1), if_rvalid_o (out, 1) and if_rdata_o (out, 32) form the instruction-fetch requester port, which is read-only.
REQ-005 Ports lsu_req_i (in, 1), lsu_we_i (in, 1), lsu_be_i (in, 4), lsu_addr_i (in, 32), lsu_wdata_i (in, 32), lsu_gnt_o (out, 1), lsu_rvalid_o (out, 1) and lsu_rdata_o (out, 32) form the load/store requester port.
REQ-006 Ports mem_req_o (out, 1), mem_we_o (out, 1), mem_be_o (out, 4), mem_addr_o (out, 32), mem_wdata_o (out, 32), mem_gnt_i (in, 1), mem_rvalid_i (in, 1) and mem_rdata_i (in, 32) form the single shared memory port.
REQ-007 Port err_o, output, 1 bit, is a sticky protocol-error flag.

Function
REQ-008 A transfer shall occur in the cycle where req and gnt are both high; memory responses arrive in order, at least 1 cycle after the grant, one per transaction, including writes.
REQ-009 Default arbitration shall be fixed priority: the LSU wins over IF.
REQ-010 The arbiter shall drive the winner's req, we, be, addr and wdata combinationally onto the mem_* outputs; the IF port shall drive we=0 and be=4'hF.
REQ-011 mem_gnt_i shall be routed combinationally to the current winner's gnt output only; the losing requester's gnt shall be 0.
REQ-012 Lock: if mem_req_o is high and mem_gnt_i is low, the selected requester shall be registered and held until it is granted, even if a higher-priority request arrives.
REQ-013 Each grant shall push the requester ID (0=IF, 1=LSU) into an ID FIFO of depth MAX_OUTST.
REQ-014 Each mem_rvalid_i shall pop the FIFO head; mem_rdata_i and rvalid shall be routed combinationally to the port named by the head, and the other port's rvalid shall be 0.
REQ-015 A push and a pop in the same cycle shall both take effect, leaving the occupancy unchanged; this shall be legal when the FIFO is full.
REQ-016 When the FIFO is full and no pop occurs this cycle, mem_req_o shall be 0 and both gnt outputs shall be 0; a lock held at that moment shall persist.
REQ-017 The FIFO pointers shall wrap modulo MAX_OUTST with no lost or duplicated IDs.
REQ-018 When mem_rvalid_i is high while the FIFO is empty, the arbiter shall set err_o, leave the FIFO state unchanged, and assert no port rvalid.
REQ-019 err_o shall clear only on reset.
REQ-020 No requests: mem_req_o shall be 0 and the mem_* payload outputs shall be 0.
REQ-021 Grant-to-visibility latency through the arbiter shall be 0 cycles in both directions.

Reset
REQ-022 Asserting rst_ni shall immediately clear the FIFO, the lock, the last-granted register and err_o.
REQ-023 During reset, all outputs shall be 0.
REQ-024 Transactions outstanding at reset are discarded, and responses after reset follow REQ-018.

Configuration
REQ-025 With macro MEM_ARB_RR_EN defined, arbitration shall be round-robin: when both ports request and no lock is held, the port not granted last wins; the last-granted register resets to IF, so the LSU wins the first tie.
REQ-026 Without MEM_ARB_RR_EN, arbitration shall be fixed priority per REQ-009, and the last-granted register shall not exist.

Verification
REQ-027 Both ports request, mem_gnt_i=1 every cycle, fixed priority -> the LSU is granted every cycle and if_gnt_o stays 0 while lsu_req_i=1.
REQ-028 IF requests addr 0x100 with gnt=0 for 3 cycles, and the LSU requests in cycle 2 -> mem_addr_o=0x100 throughout; the IF is granted in cycle 4, then the LSU.
REQ-029 MAX_OUTST=2: IF grant, then LSU grant, with no rvalid -> third request stalls with mem_req_o=0; rvalid 0xAAAA then 0xBBBB -> if_rdata_o=0xAAAA, then lsu_rdata_o=0xBBBB.
REQ-030 FIFO full, with a grant and rvalid in the same cycle -> occupancy stays 2 and IDs are delivered in order across 10 wrap-arounds.
REQ-031 mem_rvalid_i=1 with the FIFO empty -> err_o=1 next cycle and stays high; rst_ni low mid-transaction -> all outputs 0, err_o=0.
REQ-032 MEM_ARB_RR_EN defined, both ports requesting continuously, gnt=1 -> grants alternate LSU, IF, LSU, IF.
